// File: rtl/l2_server_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : l2_server_pkg                                          |
// | Description : Shared state encoding, sizing helpers and client       |
// |               index constants for the L2 page server.                |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package l2_server_pkg;

    localparam int c_WORD_W     = 16;
    localparam int c_CLIENT_TOP = 0;    // highest-priority client index

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT   = 3'd1,
        S_FETCH   = 3'd2,
        S_DELIVER = 3'd3,
        S_RELEASE = 3'd4
    } l2_state_t;

    function automatic int page_words(input int page_bytes);
        return (page_bytes < 4) ? 1 : page_bytes / 2;
    endfunction

    function automatic int idx_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_server_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : l2_server_if                                           |
// | Description : Client request bus and backing-store bus of the L2     |
// |               page server, with server (slave) and master views.     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface l2_server_if
    import l2_server_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NCLIENT = 2
);
    logic [NCLIENT-1:0]          l2_start;
    logic [NCLIENT-1:0]          l2_write;
    logic [NCLIENT*WIDTH-1:0]    l2_page;
    logic [NCLIENT*c_WORD_W-1:0] l2_wdata;
    logic                        l2_busy;
    logic [NCLIENT-1:0]          l2_launch;
    logic                        l2_ready;
    logic [c_WORD_W-1:0]         l2_data;

    logic                        mem_req;
    logic                        mem_we;
    logic [WIDTH-1:0]            mem_addr;
    logic [c_WORD_W-1:0]         mem_wdata;
    logic                        mem_ack;
    logic [c_WORD_W-1:0]         mem_rdata;

    modport slave (
        input  l2_start, l2_write, l2_page, l2_wdata, mem_ack, mem_rdata,
        output l2_busy, l2_launch, l2_ready, l2_data,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output l2_start, l2_write, l2_page, l2_wdata, mem_ack, mem_rdata,
        input  l2_busy, l2_launch, l2_ready, l2_data,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/l2_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : l2_prio_enc                                            |
// | Description : Fixed-priority encoder, lowest set bit wins.           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module l2_prio_enc
    import l2_server_pkg::*;
#(
    parameter int NCLIENT = 2,
    parameter int IDX_W   = idx_bits(NCLIENT)
) (
    input  logic [NCLIENT-1:0] i_req,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    // Scan from the top down so the lowest index is the last to overwrite.
    always_comb begin
        o_idx   = IDX_W'(c_CLIENT_TOP);
        o_valid = 1'b0;
        for (int i = NCLIENT - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_server.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : l2_server                                              |
// | Description : Serves one page at a time from backing store to the    |
// |               highest-priority requesting cache. Define L2_WRITE_EN  |
// |               to enable page write transfers.                        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module l2_server
    import l2_server_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PAGE_BYTES = 32,
    parameter int NCLIENT    = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    l2_server_if.slave  bus
);

    localparam int              c_PAGE_WORDS = page_words(PAGE_BYTES);
    localparam int              c_KW         = idx_bits(c_PAGE_WORDS);
    localparam int              c_IW         = idx_bits(NCLIENT);
    localparam logic [c_KW-1:0] c_K_LAST     = c_KW'(c_PAGE_WORDS - 1);

    l2_state_t           r_state;
    logic [c_IW-1:0]     r_idx;
    logic [WIDTH-1:0]    r_page;
    logic [c_KW-1:0]     r_k;
    logic                r_busy;
    logic [NCLIENT-1:0]  r_launch;
    logic                r_ready;
    logic [c_WORD_W-1:0] r_data;
    logic                r_mem_req;
    logic [WIDTH-1:0]    r_mem_addr;

    logic [c_IW-1:0]     w_idx;
    logic                w_valid;
    logic [WIDTH-1:0]    w_page [NCLIENT];
    logic [WIDTH-1:0]    w_base;
    logic [c_KW-1:0]     w_k_next;
    logic [WIDTH-1:0]    w_addr_next;
    logic                w_wr_xfer;

    l2_prio_enc #(
        .NCLIENT (NCLIENT),
        .IDX_W   (c_IW)
    ) u_prio (
        .i_req   (bus.l2_start),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    for (genvar g = 0; g < NCLIENT; g++) begin : g_client
        assign w_page[g] = bus.l2_page[g*WIDTH +: WIDTH];
    end

    assign w_base      = r_page * WIDTH'(c_PAGE_WORDS);
    assign w_k_next    = r_k + 1'b1;
    assign w_addr_next = w_base + WIDTH'(w_k_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_page     <= '0;
            r_k        <= '0;
            r_busy     <= 1'b0;
            r_launch   <= '0;
            r_ready    <= 1'b0;
            r_data     <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_idx   <= w_idx;
                        r_page  <= w_page[w_idx];
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_launch[r_idx] <= 1'b1;
                    r_mem_req       <= 1'b1;
                    r_mem_addr      <= w_base;
                    r_state         <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        if (!w_wr_xfer) begin
                            r_data <= bus.mem_rdata;
                        end
                        r_mem_req <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    // Ready drops here, so back-to-back words always have a gap.
                    r_ready <= 1'b0;
                    if (r_k == c_K_LAST) begin
                        r_state <= S_RELEASE;
                    end else begin
                        r_k        <= w_k_next;
                        r_mem_addr <= w_addr_next;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_RELEASE: begin
                    if (!bus.l2_start[r_idx]) begin
                        r_launch <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef L2_WRITE_EN
    logic                r_write;
    logic                r_mem_we;
    logic [c_WORD_W-1:0] r_mem_wdata;
    logic [c_WORD_W-1:0] w_wdata [NCLIENT];
    logic                w_fetch_entry;
    logic                w_fetch_done;

    for (genvar g = 0; g < NCLIENT; g++) begin : g_wdata
        assign w_wdata[g] = bus.l2_wdata[g*c_WORD_W +: c_WORD_W];
    end

    assign w_fetch_entry = (r_state == S_GRANT) ||
                           ((r_state == S_DELIVER) && (r_k != c_K_LAST));
    assign w_fetch_done  = (r_state == S_FETCH) && bus.mem_ack;
    assign w_wr_xfer     = r_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_valid) begin
                r_write <= bus.l2_write[w_idx];
            end
            // The client's write word is captured as each fetch begins.
            if (w_fetch_entry) begin
                r_mem_we    <= r_write;
                r_mem_wdata <= w_wdata[r_idx];
            end else if (w_fetch_done) begin
                r_mem_we    <= 1'b0;
            end
        end
    end

    assign bus.mem_we    = r_mem_we;
    assign bus.mem_wdata = r_mem_wdata;
`else
    logic w_unused_wr;
    assign w_unused_wr   = ^{bus.l2_write, bus.l2_wdata};
    assign w_wr_xfer     = 1'b0;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_wdata = '0;
`endif

    assign bus.l2_busy   = r_busy;
    assign bus.l2_launch = r_launch;
    assign bus.l2_ready  = r_ready;
    assign bus.l2_data   = r_data;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_l2_server.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_l2_server                                           |
// | Description : Scoreboard bench for l2_server; memory returns         |
// |               0xC000 + address. Honours L2_WRITE_EN.                 |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_l2_server;
    import l2_server_pkg::*;

    localparam int WIDTH      = 32;
    localparam int PAGE_BYTES = 32;
    localparam int NCLIENT    = 2;
    localparam int PW         = 16;

    typedef struct packed {
        logic [WIDTH-1:0] addr;
        logic             we;
        logic [15:0]      wdata;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_server_if #(.WIDTH(WIDTH), .NCLIENT(NCLIENT)) bus ();

    l2_server #(
        .WIDTH      (WIDTH),
        .PAGE_BYTES (PAGE_BYTES),
        .NCLIENT    (NCLIENT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Backing store: ack tied high, or ack after ack_lat waiting cycles.
    bit ack_tie = 1'b1;
    int ack_lat = 0;
    int wait_cnt = 0;
    assign bus.mem_ack   = ack_tie | (bus.mem_req && (wait_cnt == ack_lat));
    assign bus.mem_rdata = 16'hC000 + bus.mem_addr[15:0];
    always @(posedge clk) wait_cnt <= (bus.mem_req && !bus.mem_ack) ? wait_cnt + 1 : 0;

    mem_exp_t    mem_q [$];
    logic [15:0] data_q [$];
    logic [15:0] last_rd = 16'h0;
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_xfer(input logic [WIDTH-1:0] page, input bit wr);
        for (int k = 0; k < PW; k++) begin
            mem_exp_t e;
            logic [WIDTH-1:0] a;
            a = page * PW + k;
            e.addr = a;
`ifdef L2_WRITE_EN
            e.we    = wr;
            e.wdata = wr ? 16'hA5A0 + 16'(k) : 16'h0;
`else
            e.we    = 1'b0;
            e.wdata = 16'h0;
`endif
            mem_q.push_back(e);
            if (!e.we) last_rd = 16'hC000 + a[15:0];
            data_q.push_back(last_rd);
        end
    endtask

    task automatic issue(input int c, input logic [WIDTH-1:0] page, input bit wr);
        bus.l2_page[c*WIDTH +: WIDTH] = page;
        bus.l2_write[c] = wr;
        bus.l2_start[c] = 1'b1;
    endtask

    task automatic wait_drained(input int budget, input bit upd_wd);
        int n;
        int wd_k;
        n = 0;
        wd_k = 0;
        while ((mem_q.size() != 0 || data_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
            if (upd_wd && bus.l2_ready) begin
                wd_k++;
                bus.l2_wdata[15:0] = 16'hA5A0 + 16'(wd_k);
            end
        end
        vectors++;
        if (mem_q.size() != 0 || data_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: mem_left=%0d data_left=%0d after %0d cycles",
                     mem_q.size(), data_q.size(), n);
            mem_q.delete();
            data_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   bus.l2_busy,   0);
        check({tag, "_launch"}, bus.l2_launch, 0);
        check({tag, "_ready"},  bus.l2_ready,  0);
        check({tag, "_data"},   bus.l2_data,   0);
        check({tag, "_req"},    bus.mem_req,   0);
        check({tag, "_we"},     bus.mem_we,    0);
        check({tag, "_addr"},   bus.mem_addr,  0);
        check({tag, "_wdata"},  bus.mem_wdata, 0);
    endtask

    // Monitor: pops the scoreboard on every accepted access and ready pulse.
    initial begin
        logic             prev_ready;
        logic             prev_wait;
        logic [WIDTH-1:0] prev_addr;
        mem_exp_t         e;
        prev_ready = 1'b0;
        prev_wait  = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mem_req && prev_wait) begin
                    vectors++;
                    if (bus.mem_addr !== prev_addr) begin
                        miscompares++;
                        $display("FAIL addr_stable: got %h expected %h", bus.mem_addr, prev_addr);
                    end
                end
                if (bus.mem_req && bus.mem_ack) begin
                    vectors++;
                    if (mem_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL mem_unexpected: got access addr=%h, none expected", bus.mem_addr);
                    end else begin
                        e = mem_q.pop_front();
                        if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== e) begin
                            miscompares++;
                            $display("FAIL mem_access: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                                     bus.mem_addr, bus.mem_we, bus.mem_wdata, e.addr, e.we, e.wdata);
                        end
                    end
                end
                if (bus.l2_ready) begin
                    vectors++;
                    if (prev_ready) begin
                        miscompares++;
                        $display("FAIL ready_gap: got back-to-back ready, expected idle cycle");
                    end
                    if (data_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL ready_unexpected: got ready data=%h, none expected", bus.l2_data);
                    end else if (bus.l2_data !== data_q[0]) begin
                        miscompares++;
                        $display("FAIL ready_data: got %h expected %h", bus.l2_data, data_q[0]);
                        void'(data_q.pop_front());
                    end else begin
                        void'(data_q.pop_front());
                    end
                end
            end
            prev_ready = bus.l2_ready;
            prev_wait  = bus.mem_req && !bus.mem_ack;
            prev_addr  = bus.mem_addr;
        end
    end

    initial begin
        int n_rdy;
        int n;
        rst = 1'b1;
        bus.l2_start = '0;
        bus.l2_write = '0;
        bus.l2_page  = '0;
        bus.l2_wdata = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single read: client 1, page 3 -> addresses 0x30..0x3F, data 0xC030..0xC03F.
        @(negedge clk);
        issue(1, 32'h3, 1'b0);
        push_xfer(32'h3, 1'b0);
        repeat (2) @(negedge clk);
        check("read_launch", bus.l2_launch, 2'b10);
        check("read_busy",   bus.l2_busy,   1);
        wait_drained(200, 1'b0);
        @(negedge clk);
        check("read_busy_held", bus.l2_busy, 1);
        bus.l2_start[1] = 1'b0;
        @(negedge clk);
        check("read_busy_drop",   bus.l2_busy,   0);
        check("read_launch_drop", bus.l2_launch, 0);

        // Collision: client 0 page 7 wins, client 1 page 9 retries afterwards.
        issue(0, 32'h7, 1'b0);
        issue(1, 32'h9, 1'b0);
        push_xfer(32'h7, 1'b0);
        repeat (2) @(negedge clk);
        check("coll_launch",       bus.l2_launch,    2'b01);
        check("coll_loser_launch", bus.l2_launch[1], 0);
        wait_drained(200, 1'b0);
        @(negedge clk);
        push_xfer(32'h9, 1'b0);
        bus.l2_start[0] = 1'b0;
        @(negedge clk);
        check("coll_busy_gap", bus.l2_busy, 0);
        repeat (2) @(negedge clk);
        check("coll_retry_launch", bus.l2_launch, 2'b10);
        wait_drained(200, 1'b0);
        bus.l2_start[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("coll_busy_end", bus.l2_busy, 0);

        // Slow memory: ack three cycles after each request, page 2.
        ack_tie = 1'b0;
        ack_lat = 3;
        issue(0, 32'h2, 1'b0);
        push_xfer(32'h2, 1'b0);
        wait_drained(600, 1'b0);
        @(negedge clk);
        bus.l2_start[0] = 1'b0;
        @(negedge clk);
        check("slow_busy_end", bus.l2_busy, 0);
        ack_tie = 1'b1;
        ack_lat = 0;

        // Held start: page 0xA stays requested 5 cycles past the last word.
        issue(1, 32'hA, 1'b0);
        push_xfer(32'hA, 1'b0);
        wait_drained(200, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("held_busy",   bus.l2_busy,   1);
            check("held_launch", bus.l2_launch, 2'b10);
        end
        bus.l2_start[1] = 1'b0;
        @(negedge clk);
        check("held_busy_end", bus.l2_busy, 0);

        // Reset after word 5 of page 5, then the page restarts from 0x50.
        issue(0, 32'h5, 1'b0);
        push_xfer(32'h5, 1'b0);
        n_rdy = 0;
        n = 0;
        while (n_rdy < 6 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.l2_ready) n_rdy++;
        end
        check("rst_mid_words_seen", n_rdy, 6);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        mem_q.delete();
        data_q.delete();
        last_rd = 16'h0;
        bus.l2_start = '0;
        repeat (2) @(negedge clk);
        check("rst_hold_req", bus.mem_req, 0);
        rst = 1'b0;
        @(negedge clk);
        issue(0, 32'h5, 1'b0);
        push_xfer(32'h5, 1'b0);
        wait_drained(200, 1'b0);
        bus.l2_start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_retry_busy_end", bus.l2_busy, 0);

        // Write page 1 from client 0 with words 0xA5A0+k (a read when disabled).
        bus.l2_wdata[15:0] = 16'hA5A0;
        issue(0, 32'h1, 1'b1);
        push_xfer(32'h1, 1'b1);
        wait_drained(200, 1'b1);
        bus.l2_start[0] = 1'b0;
        bus.l2_write[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("write_busy_end", bus.l2_busy, 0);
        check("write_we_idle",  bus.mem_we,  0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier end");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
